// File: rtl/conv_core_if.sv
`default_nettype none
// ============================================================================
//  Module   : conv_core_if
//  Purpose  : Control, size and memory-port bundle between the AIP wrapper
//             (master) and the convolution core (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface conv_core_if #(
    parameter int DATAWIDTH = 32,
    parameter int AW_X      = 5,
    parameter int AW_Y      = 5,
    parameter int AW_Z      = 6
) ();
    logic                 en_s;
    logic                 start;
    logic [AW_X:0]        size_x;
    logic [AW_Y:0]        size_y;
    logic [AW_X-1:0]      memX_addr;
    logic [DATAWIDTH-1:0] memX_data;
    logic [AW_Y-1:0]      memY_addr;
    logic [DATAWIDTH-1:0] memY_data;
    logic [AW_Z-1:0]      memZ_addr;
    logic [DATAWIDTH-1:0] memZ_data;
    logic                 memZ_we;
    logic                 busy;
    logic                 done;

    modport master (
        output en_s, start, size_x, size_y, memX_data, memY_data,
        input  memX_addr, memY_addr, memZ_addr, memZ_data, memZ_we, busy, done
    );

    modport slave (
        input  en_s, start, size_x, size_y, memX_data, memY_data,
        output memX_addr, memY_addr, memZ_addr, memZ_data, memZ_we, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/conv_core.sv
`default_nettype none
// ============================================================================
//  Module   : conv_core
//  Purpose  : 1-D convolution engine Z[k] = sum X[i]*Y[k-i], one output per
//             SETUP/FETCH.../DRAIN/WRITE pass, reading synchronous memories.
//  Revision : 1.0  initial release
// ============================================================================
module conv_core #(
    parameter int DATAWIDTH = 32,
    parameter int AW_X      = 5,
    parameter int AW_Y      = 5,
    parameter int AW_Z      = 6
) (
    input  logic       clk,
    input  logic       rst,
    conv_core_if.slave bus
);
    localparam int c_KW = AW_Z + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_FETCH = 3'd2,
        S_DRAIN = 3'd3,
        S_WRITE = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_next;

    logic [AW_X:0]        r_n;
    logic [AW_Y:0]        r_m;
    logic [AW_Z-1:0]      r_k;
    logic [AW_X-1:0]      r_i;
    logic [AW_X-1:0]      r_ihi;
    logic [AW_Y-1:0]      r_j;
    logic [DATAWIDTH-1:0] r_acc;
    logic                 r_pv;
    logic                 r_en_q;
    logic [DATAWIDTH-1:0] r_skid_x;
    logic [DATAWIDTH-1:0] r_skid_y;

    logic [c_KW-1:0]      w_k_ext;
    logic [c_KW-1:0]      w_n_ext;
    logic [c_KW-1:0]      w_m_ext;
    logic [c_KW-1:0]      w_kp1;
    logic [c_KW-1:0]      w_ilo;
    logic [c_KW-1:0]      w_nm1;
    logic [c_KW-1:0]      w_ihi;
    logic [c_KW-1:0]      w_kmi;
    logic [c_KW-1:0]      w_klast;
    logic                 w_k_last;
    logic                 w_last_term;
    logic                 w_zero_size;
    logic [DATAWIDTH-1:0] w_x_op;
    logic [DATAWIDTH-1:0] w_y_op;
    logic [DATAWIDTH-1:0] w_prod;
    logic                 w_busy;
    logic                 w_done;
    logic                 w_we;
    logic                 w_unused_bits;

    // Window of contributing X indices for the current output k
    assign w_k_ext     = c_KW'(r_k);
    assign w_n_ext     = c_KW'(r_n);
    assign w_m_ext     = c_KW'(r_m);
    assign w_kp1       = w_k_ext + c_KW'(1);
    assign w_ilo       = (w_kp1 > w_m_ext) ? (w_kp1 - w_m_ext) : '0;
    assign w_nm1       = w_n_ext - c_KW'(1);
    assign w_ihi       = (w_k_ext < w_nm1) ? w_k_ext : w_nm1;
    assign w_kmi       = w_k_ext - w_ilo;
    assign w_klast     = w_n_ext + w_m_ext - c_KW'(2);
    assign w_k_last    = (w_k_ext == w_klast);
    assign w_last_term = (r_i == r_ihi);
    assign w_zero_size = (bus.size_x == '0) || (bus.size_y == '0);

    assign w_unused_bits = ^{w_ilo[c_KW-1:AW_X], w_ihi[c_KW-1:AW_X], w_kmi[c_KW-1:AW_Y]};

    // The memories keep reading through an en_s stall, so the word that was
    // valid on the first stalled cycle is held and used on resumption.
    assign w_x_op = r_en_q ? bus.memX_data : r_skid_x;
    assign w_y_op = r_en_q ? bus.memY_data : r_skid_y;
    assign w_prod = w_x_op * w_y_op;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else if (bus.en_s) begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        w_we   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next = w_zero_size ? S_FIN : S_SETUP;
                end
            end
            S_SETUP: begin
                w_busy = 1'b1;
                w_next = S_FETCH;
            end
            S_FETCH: begin
                w_busy = 1'b1;
                if (w_last_term) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_busy = 1'b1;
                w_next = S_WRITE;
            end
            S_WRITE: begin
                w_busy = 1'b1;
                w_we   = bus.en_s;
                w_next = w_k_last ? S_FIN : S_SETUP;
            end
            S_FIN: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_n   <= '0;
            r_m   <= '0;
            r_k   <= '0;
            r_i   <= '0;
            r_ihi <= '0;
            r_j   <= '0;
            r_acc <= '0;
            r_pv  <= 1'b0;
        end else if (bus.en_s) begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_n <= bus.size_x;
                        r_m <= bus.size_y;
                        r_k <= '0;
                    end
                end
                S_SETUP: begin
                    r_i   <= w_ilo[AW_X-1:0];
                    r_ihi <= w_ihi[AW_X-1:0];
                    r_j   <= w_kmi[AW_Y-1:0];
                    r_acc <= '0;
                end
                S_FETCH: begin
                    if (r_pv) begin
                        r_acc <= r_acc + w_prod;
                    end
                    if (!w_last_term) begin
                        r_i <= r_i + AW_X'(1);
                        r_j <= r_j - AW_Y'(1);
                    end
                end
                S_DRAIN: begin
                    if (r_pv) begin
                        r_acc <= r_acc + w_prod;
                    end
                end
                S_WRITE: begin
                    if (!w_k_last) begin
                        r_k <= r_k + AW_Z'(1);
                    end
                end
                default: begin
                end
            endcase
            r_pv <= (r_state == S_FETCH);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_en_q   <= 1'b1;
            r_skid_x <= '0;
            r_skid_y <= '0;
        end else begin
            r_en_q <= bus.en_s;
            if (r_en_q && !bus.en_s) begin
                r_skid_x <= bus.memX_data;
                r_skid_y <= bus.memY_data;
            end
        end
    end

    assign bus.memX_addr = r_i;
    assign bus.memY_addr = r_j;
    assign bus.memZ_addr = r_k;
    assign bus.memZ_data = r_acc;
    assign bus.memZ_we   = w_we;
    assign bus.busy      = w_busy;
    assign bus.done      = w_done;

endmodule
`default_nettype wire

// File: tb/tb_conv_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv_core
//  Purpose  : Self-checking bench for conv_core: vector table, corner
//             sequences and randomized jobs against a direct-sum model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_conv_core;
    localparam int DW  = 32;
    localparam int AWX = 5;
    localparam int AWY = 5;
    localparam int AWZ = 6;

    logic clk = 1'b0;
    logic rst;

    conv_core_if #(.DATAWIDTH(DW), .AW_X(AWX), .AW_Y(AWY), .AW_Z(AWZ)) bus ();

    conv_core #(.DATAWIDTH(DW), .AW_X(AWX), .AW_Y(AWY), .AW_Z(AWZ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] memx [0:31];
    logic [DW-1:0] memy [0:31];

    always @(posedge clk) begin
        bus.memX_data <= memx[bus.memX_addr];
        bus.memY_data <= memy[bus.memY_addr];
    end

    logic [AWZ-1:0] log_addr [$];
    logic [DW-1:0]  log_data [$];
    int             bad_we = 0;

    always @(posedge clk) begin
        if (!rst && bus.memZ_we) begin
            log_addr.push_back(bus.memZ_addr);
            log_data.push_back(bus.memZ_data);
        end
        if (bus.memZ_we && !bus.en_s) begin
            bad_we <= bad_we + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Direct sum over all (i, k-i) pairs inside both sequences
    function automatic logic [DW-1:0] ref_z(input int k, input int n, input int m);
        logic [DW-1:0] acc;
        logic [DW-1:0] p;
        acc = '0;
        for (int i = 0; i < n; i++) begin
            if ((k - i) >= 0 && (k - i) < m) begin
                p   = memx[i] * memy[k - i];
                acc = acc + p;
            end
        end
        return acc;
    endfunction

    function automatic int ref_latency(input int n, input int m);
        int terms;
        if (n == 0 || m == 0) return 2;
        terms = 0;
        for (int k = 0; k < n + m - 1; k++) begin
            for (int i = 0; i < n; i++) begin
                if ((k - i) >= 0 && (k - i) < m) terms++;
            end
            terms += 3;
        end
        return terms + 2;
    endfunction

    typedef struct packed {
        int                 n;
        int                 m;
        int                 lat;
        int                 nz;
        logic [3:0][DW-1:0] x;
        logic [3:0][DW-1:0] y;
        logic [5:0][DW-1:0] z;
    } vec_t;

    vec_t vecs [7];

    task automatic load_vec(input vec_t t);
        for (int i = 0; i < 32; i++) begin
            memx[i] = $urandom;
            memy[i] = $urandom;
        end
        for (int i = 0; i < 4; i++) begin
            if (i < t.n) memx[i] = t.x[i];
            if (i < t.m) memy[i] = t.y[i];
        end
    endtask

    task automatic run_job(input string tag, input int n, input int m,
                           input int stall_at, input int stall_len, input int restart_at,
                           input int exp_lat, output int base);
        int cyc;
        int busy_low;
        int base_bad;
        int nz;
        bit seen;
        base      = log_data.size();
        base_bad  = bad_we;
        busy_low  = 0;
        seen      = 1'b0;
        bus.size_x = n[AWX:0];
        bus.size_y = m[AWY:0];
        bus.start  = 1'b1;
        cyc        = 1;
        while (!seen && cyc < exp_lat + 40) begin
            @(posedge clk);
            #1;
            cyc++;
            bus.start = 1'b0;
            if (cyc == restart_at) begin
                bus.start  = 1'b1;
                bus.size_x = 6'd3;
                bus.size_y = 6'd9;
            end
            if (cyc == stall_at) bus.en_s = 1'b0;
            if (cyc == stall_at + stall_len) bus.en_s = 1'b1;
            if (bus.done) seen = 1'b1;
            else if (n != 0 && m != 0 && !bus.busy) busy_low++;
        end
        bus.en_s = 1'b1;
        check({tag, ".latency"}, 64'(cyc), 64'(exp_lat));
        check({tag, ".busy_with_done"}, 64'(bus.busy), 64'(0));
        if (!seen) begin
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check({tag, ".idle_after_done"}, 64'({bus.busy, bus.done}), 64'(0));
        nz = (n > 0 && m > 0) ? n + m - 1 : 0;
        check({tag, ".writes"}, 64'(log_data.size() - base), 64'(nz));
        check({tag, ".we_in_stall"}, 64'(bad_we - base_bad), 64'(0));
        check({tag, ".busy_run"}, 64'(busy_low), 64'(0));
    endtask

    task automatic check_model(input string tag, input int base, input int n, input int m);
        int nz;
        nz = (n > 0 && m > 0) ? n + m - 1 : 0;
        for (int k = 0; k < nz && base + k < log_data.size(); k++) begin
            check($sformatf("%s.zaddr%0d", tag, k), 64'(log_addr[base + k]), 64'(k));
            check($sformatf("%s.z%0d", tag, k), 64'(log_data[base + k]), 64'(ref_z(k, n, m)));
        end
    endtask

    task automatic check_table_z(input string tag, input int base, input vec_t t);
        for (int k = 0; k < t.nz && base + k < log_data.size(); k++) begin
            check($sformatf("%s.zaddr%0d", tag, k), 64'(log_addr[base + k]), 64'(k));
            check($sformatf("%s.z%0d", tag, k), 64'(log_data[base + k]), 64'(t.z[k]));
        end
    endtask

    initial begin
        int base;
        int n;
        int m;
        int nom;
        int s_at;
        int s_len;
        int r_at;

        vecs[0] = '{4, 3, 32, 6, {32'd4, 32'd3, 32'd2, 32'd1}, {32'd0, 32'd1, 32'd1, 32'd1},
                    {32'd4, 32'd7, 32'd9, 32'd6, 32'd3, 32'd1}};
        vecs[1] = '{1, 1, 6, 1, {32'd0, 32'd0, 32'd0, 32'd5}, {32'd0, 32'd0, 32'd0, 32'd7},
                    {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'h23}};
        vecs[2] = '{1, 1, 6, 1, {32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF}, {32'd0, 32'd0, 32'd0, 32'd2},
                    {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFE}};
        vecs[3] = '{0, 3, 2, 0, {32'd0, 32'd0, 32'd0, 32'd0}, {32'd0, 32'd1, 32'd1, 32'd1},
                    {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0}};
        vecs[4] = '{3, 0, 2, 0, {32'd0, 32'd1, 32'd2, 32'd3}, {32'd0, 32'd0, 32'd0, 32'd0},
                    {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0}};
        vecs[5] = '{2, 2, 15, 3, {32'd0, 32'd0, 32'd5, 32'd3}, {32'd0, 32'd0, 32'd4, 32'd2},
                    {32'd0, 32'd0, 32'd0, 32'd20, 32'd22, 32'd6}};
        vecs[6] = '{4, 1, 18, 4, {32'd40, 32'd30, 32'd20, 32'd10}, {32'd0, 32'd0, 32'd0, 32'd3},
                    {32'd0, 32'd0, 32'd120, 32'd90, 32'd60, 32'd30}};

        for (int i = 0; i < 32; i++) begin
            memx[i] = $urandom;
            memy[i] = $urandom;
        end
        rst        = 1'b1;
        bus.en_s   = 1'b1;
        bus.start  = 1'b0;
        bus.size_x = '0;
        bus.size_y = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("reset.busy", 64'(bus.busy), 64'(0));
        check("reset.done", 64'(bus.done), 64'(0));
        check("reset.we", 64'(bus.memZ_we), 64'(0));
        check("reset.xaddr", 64'(bus.memX_addr), 64'(0));
        check("reset.yaddr", 64'(bus.memY_addr), 64'(0));
        check("reset.zaddr", 64'(bus.memZ_addr), 64'(0));
        check("reset.zdata", 64'(bus.memZ_data), 64'(0));

        for (int v = 0; v < 7; v++) begin
            load_vec(vecs[v]);
            run_job($sformatf("vec%0d", v), vecs[v].n, vecs[v].m, -1, 0, -1, vecs[v].lat, base);
            check_table_z($sformatf("vec%0d", v), base, vecs[v]);
        end

        // Second start mid-run plus a 5-cycle stall inside FETCH of k=2
        load_vec(vecs[0]);
        run_job("perturb", 4, 3, 12, 5, 6, 37, base);
        check_table_z("perturb", base, vecs[0]);

        // Stall landing on the WRITE of k=0: the write must be re-issued
        load_vec(vecs[0]);
        run_job("stall_wr", 4, 3, 5, 3, -1, 35, base);
        check_table_z("stall_wr", base, vecs[0]);

        // Stall on DRAIN, and a start arriving in the same cycle as done
        load_vec(vecs[5]);
        run_job("stall_dr", 2, 2, 4, 2, 17, 17, base);
        check_table_z("stall_dr", base, vecs[5]);

        // Reset while fetching k=2 of the N=4, M=3 job
        load_vec(vecs[0]);
        base       = log_data.size();
        bus.size_x = 6'd4;
        bus.size_y = 6'd3;
        bus.start  = 1'b1;
        repeat (11) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        check("rstmid.busy_before", 64'(bus.busy), 64'(1));
        check("rstmid.xaddr", 64'(bus.memX_addr), 64'(0));
        check("rstmid.yaddr", 64'(bus.memY_addr), 64'(2));
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rstmid.busy", 64'(bus.busy), 64'(0));
        check("rstmid.done", 64'(bus.done), 64'(0));
        check("rstmid.we", 64'(bus.memZ_we), 64'(0));
        check("rstmid.zdata", 64'(bus.memZ_data), 64'(0));
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("rstmid.writes", 64'(log_data.size() - base), 64'(2));
        check_table_z("rstmid", base, '{4, 3, 32, 2, vecs[0].x, vecs[0].y, vecs[0].z});
        run_job("after_rst", 4, 3, -1, 0, -1, 32, base);
        check_table_z("after_rst", base, vecs[0]);

        // Randomized jobs against the direct-sum model
        for (int t = 0; t < 26; t++) begin
            n = (t == 25) ? 32 : int'($urandom_range(0, 10));
            m = (t == 25) ? 32 : int'($urandom_range(0, 10));
            for (int i = 0; i < 32; i++) begin
                memx[i] = $urandom;
                memy[i] = $urandom;
            end
            nom   = ref_latency(n, m);
            s_at  = -1;
            s_len = 0;
            r_at  = -1;
            if (nom > 3 && $urandom_range(0, 1) == 1) begin
                s_at  = int'($urandom_range(2, nom - 1));
                s_len = int'($urandom_range(1, 4));
            end
            if ($urandom_range(0, 1) == 1) begin
                r_at = int'($urandom_range(2, nom));
            end
            run_job($sformatf("rnd%0d_%0dx%0d", t, n, m), n, m, s_at, s_len, r_at, nom + s_len, base);
            check_model($sformatf("rnd%0d", t), base, n, m);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/conv_core.md
Name: conv_core

Overview:
- Temporal (1-D discrete) convolution engine; sits directly downstream of the AIP interface wrapper.
- The wrapper's host-loaded input memories (X samples, Y kernel) feed this block through synchronous-read ports.
- Computes Z[k] = sum over i of X[i]*Y[k-i], k = 0..N+M-2, and writes Z into the wrapper's output memory.
- The wrapper maps busy/done onto the STATUS register and the done interrupt bit.

Parameters:
- DATAWIDTH, 32, sample/accumulator width (unsigned, modulo 2^DATAWIDTH).
- AW_X, 5, address width of X memory; max N = 2^AW_X.
- AW_Y, 5, address width of Y memory; max M = 2^AW_Y.
- AW_Z, 6, address width of Z memory; must satisfy 2^AW_Z >= 2^AW_X + 2^AW_Y - 1.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en_s  in  1  synchronous enable; 0 freezes all state, outputs hold
- start  in  1  one-cycle start request, sampled only in IDLE
- size_x  in  AW_X+1  N, number of X samples (0..2^AW_X)
- size_y  in  AW_Y+1  M, number of Y samples (0..2^AW_Y)
- memX_addr  out  AW_X  X read address
- memX_data  in  DATAWIDTH  X read data, valid 1 cycle after address
- memY_addr  out  AW_Y  Y read address
- memY_data  in  DATAWIDTH  Y read data, valid 1 cycle after address
- memZ_addr  out  AW_Z  Z write address
- memZ_data  out  DATAWIDTH  Z write data
- memZ_we  out  1  Z write strobe, one cycle per output sample
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at completion

Behaviour:
- Interface: one clock (clk); synchronous, active-high reset (rst).
- Reset: state=IDLE; busy=0, done=0, memZ_we=0; all addresses=0; memZ_data=0; accumulator=0. Reset mid-operation aborts immediately with no further Z writes; Z contents already written are left as is.
- en_s=0: no state/counter/output change; memZ_we is forced low during that cycle and the pending write is re-issued when en_s returns to 1.
- States: IDLE, SETUP, FETCH, DRAIN, WRITE, FIN.
- IDLE: start=1 -> latch N and M; busy=1 next cycle.
  - If N=0 or M=0 -> FIN (no Z writes).
  - Otherwise -> SETUP with k=0.
- SETUP (1 cycle): i_lo=max(0,k-M+1), i_hi=min(k,N-1); i=i_lo; acc=0.
- FETCH: drive memX_addr=i and memY_addr=k-i.
  - Product of the previous address pair is added to acc (pipeline stage).
  - i increments each cycle; after issuing i_hi -> DRAIN.
- DRAIN (1 cycle): add the last product.
- WRITE (1 cycle): memZ_we=1, memZ_addr=k, memZ_data=acc.
  - If k=N+M-2 -> FIN; else k+1 and -> SETUP.
- FIN (1 cycle): done=1, busy=0; -> IDLE.
- Arithmetic: product and accumulation truncated to the low DATAWIDTH bits, unsigned; no saturation.
- Terms per output: T_k = i_hi-i_lo+1; the sum of T_k equals N*M.
- Latency: start edge to done pulse = 1 + N*M + 3*(N+M-1) + 1 cycles (SETUP+DRAIN+WRITE per output, plus accept and FIN). Example: N=4, M=3 gives 32 cycles.
- start while not in IDLE: ignored. start and done in the same cycle: the start is ignored.
- size_x/size_y changes during busy: ignored (latched values are used).

Test Plan:
- X=[1,2,3,4], Y=[1,1,1], N=4, M=3 -> six writes, Z[0..5]=[1,3,6,9,7,4]; done exactly 32 cycles after start.
- N=1, M=1, X=[5], Y=[7] -> single write Z[0]=35 (0x23); done 6 cycles after start; busy low with done.
- X=[0xFFFFFFFF], Y=[2] -> Z[0]=0xFFFFFFFE (wrap).
- Second start pulse mid-run, then en_s=0 for 5 cycles mid-run -> identical Z values to the unperturbed run; second start ignored; done delayed by exactly 5 cycles; no memZ_we while en_s=0.
- N=0, M=3 -> no memZ_we; done 2 cycles after start.
- rst=1 during FETCH of k=2 (N=4, M=3) -> next cycle busy=0, done=0, memZ_we=0; new start then produces the full correct Z sequence.
